ad_impression_tracker: RTL and testbench

Downstream stage of the `movies` ad selector. It accepts the selected ad code per visitor request and enforces a per-ad impression budget. If the requested ad's budget is spent, it substitutes the fallback ad "Saving Lincoln" (2'b11). If the fallback is also spent, the request is dropped. Served ads are presented to the page renderer through a one-entry registered valid/ready output.

---
 rtl/ad_impression_tracker_pkg.sv | 15 +
 rtl/ad_budget_counter.sv | 49 ++++
 rtl/ad_impression_tracker.sv | 150 +++++++++++++++
 tb/tb_ad_impression_tracker.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ad_impression_tracker_pkg.sv
// Shared ad codes and output-buffer state type for the impression tracker.
package ad_pkg;

  localparam logic [1:0] AD_DIE_HARD   = 2'b00;
  localparam logic [1:0] AD_SAFE_HAVEN = 2'b01;
  localparam logic [1:0] AD_ESCAPE     = 2'b10;
  localparam logic [1:0] AD_LINCOLN    = 2'b11;
  localparam logic [1:0] AD_FALLBACK   = AD_LINCOLN;

  typedef enum logic {
    BUF_EMPTY = 1'b0,
    BUF_FULL  = 1'b1
  } buf_state_e;

endpackage

// File: rtl/ad_budget_counter.sv
// Impression counter for one ad code. It saturates at BUDGET and supports a
// synchronous clear. A clear together with an increment leaves the count at 1.
module ad_budget_counter #(
  parameter int CNT_W  = 16,
  parameter int BUDGET = 1000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count,
  output logic             exhausted
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(BUDGET);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

  logic [CNT_W-1:0] count_d;
  logic [CNT_W-1:0] count_q;

  // Next count: clear wins over hold, and an increment never passes the limit.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      if (inc) begin
        count_d = ONE;
      end else begin
        count_d = '0;
      end
    end else if (inc && (count_q != LIMIT)) begin
      count_d = count_q + ONE;
    end else begin
      count_d = count_q;
    end
  end

  // Counter register; the asynchronous reset zeroes the count immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count     = count_q;
  assign exhausted = (count_q == LIMIT);

endmodule

// File: rtl/ad_impression_tracker.sv
// Enforces a per-ad impression budget. When the requested ad is spent, the
// fallback ad is substituted; when the fallback is also spent, the request is
// dropped. Served ads are held in a one-entry registered valid/ready buffer.
module ad_impression_tracker
  import ad_pkg::*;
#(
  parameter int CNT_W  = 16,
  parameter int BUDGET = 1000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_ad,
  output logic             srv_valid,
  input  logic             srv_ready,
  output logic [1:0]       srv_ad,
  output logic             srv_sub,
  output logic             drop,
  input  logic             clear,
  input  logic [1:0]       cnt_sel,
  output logic [CNT_W-1:0] cnt_out
);

  logic [3:0]       inc_s;
  logic [3:0]       exh_s;
  logic [CNT_W-1:0] cnt_s [4];

  logic       accept_s;
  logic       serve_s;
  logic [1:0] serve_ad_s;
  logic       serve_sub_s;

  buf_state_e state_q, state_d;
  logic [1:0] srv_ad_q, srv_ad_d;
  logic       srv_sub_q, srv_sub_d;
  logic       drop_q, drop_d;

  for (genvar gi = 0; gi < 4; gi++) begin : g_cnt
    ad_budget_counter #(
      .CNT_W (CNT_W),
      .BUDGET(BUDGET)
    ) u_cnt (
      .clk      (clk),
      .rst_n    (rst_n),
      .inc      (inc_s[gi]),
      .clr      (clear),
      .count    (cnt_s[gi]),
      .exhausted(exh_s[gi])
    );
  end

  // The stage can take a request whenever the buffer is free or is being drained.
  assign req_ready = (state_q == BUF_EMPTY) || srv_ready;
  assign accept_s  = req_valid && req_ready;

  // Serve decision on the pre-update counts: requested ad, then fallback, then drop.
  always_comb begin
    serve_s     = 1'b0;
    serve_ad_s  = req_ad;
    serve_sub_s = 1'b0;
    drop_d      = 1'b0;
    inc_s       = 4'b0000;
    if (accept_s) begin
      if (!exh_s[req_ad]) begin
        serve_s     = 1'b1;
        serve_ad_s  = req_ad;
        serve_sub_s = 1'b0;
      end else if (!exh_s[AD_FALLBACK]) begin
        serve_s     = 1'b1;
        serve_ad_s  = AD_FALLBACK;
        serve_sub_s = 1'b1;
      end else begin
        drop_d = 1'b1;
      end
    end else begin
      drop_d = 1'b0;
    end
    if (serve_s) begin
      inc_s[serve_ad_s] = 1'b1;
    end else begin
      inc_s = 4'b0000;
    end
  end

  // Output buffer next state: a served accept always (re)loads; a drain empties.
  always_comb begin
    state_d   = state_q;
    srv_ad_d  = srv_ad_q;
    srv_sub_d = srv_sub_q;
    case (state_q)
      BUF_EMPTY: begin
        if (serve_s) begin
          state_d   = BUF_FULL;
          srv_ad_d  = serve_ad_s;
          srv_sub_d = serve_sub_s;
        end else begin
          state_d = BUF_EMPTY;
        end
      end
      BUF_FULL: begin
        if (serve_s) begin
          state_d   = BUF_FULL;
          srv_ad_d  = serve_ad_s;
          srv_sub_d = serve_sub_s;
        end else if (srv_ready) begin
          state_d = BUF_EMPTY;
        end else begin
          state_d = BUF_FULL;
        end
      end
      default: begin
        state_d = BUF_EMPTY;
      end
    endcase
  end

  // Output buffer FSM with its registered payload and the drop pulse flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= BUF_EMPTY;
      srv_ad_q  <= AD_DIE_HARD;
      srv_sub_q <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      srv_ad_q  <= srv_ad_d;
      srv_sub_q <= srv_sub_d;
      drop_q    <= drop_d;
    end
  end

  assign srv_valid = (state_q == BUF_FULL);
  assign srv_ad    = srv_ad_q;
  assign srv_sub   = srv_sub_q;
  assign drop      = drop_q;

  // Combinational counter readback.
  always_comb begin
    cnt_out = '0;
    case (cnt_sel)
      2'b00:   cnt_out = cnt_s[0];
      2'b01:   cnt_out = cnt_s[1];
      2'b10:   cnt_out = cnt_s[2];
      2'b11:   cnt_out = cnt_s[3];
      default: cnt_out = '0;
    endcase
  end

endmodule

// File: tb/tb_ad_impression_tracker.sv
// Scoreboard bench for ad_impression_tracker: a stimulus process drives directed
// and random traffic and feeds a budget model; a negedge monitor compares.
module tb_ad_impression_tracker;

  localparam int CNT_W  = 8;
  localparam int BUDGET = 6;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req_valid;
  logic             req_ready;
  logic [1:0]       req_ad;
  logic             srv_valid;
  logic             srv_ready;
  logic [1:0]       srv_ad;
  logic             srv_sub;
  logic             drop;
  logic             clear;
  logic [1:0]       cnt_sel;
  logic [CNT_W-1:0] cnt_out;

  ad_impression_tracker #(.CNT_W(CNT_W), .BUDGET(BUDGET)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_ad(req_ad), .srv_valid(srv_valid), .srv_ready(srv_ready),
    .srv_ad(srv_ad), .srv_sub(srv_sub), .drop(drop), .clear(clear),
    .cnt_sel(cnt_sel), .cnt_out(cnt_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] ad;
    logic       sub;
  } srv_t;

  srv_t exp_q[$];
  int   m_cnt[4];
  bit   m_full;
  bit   exp_drop;
  bit   mon_en;
  bit   hold;
  srv_t held;
  int   checks;
  int   errors;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Budget rules applied to the inputs that the last rising edge sampled.
  task automatic model_step();
    bit   acc;
    bit   served;
    srv_t item;
    acc      = req_valid && (!m_full || srv_ready);
    served   = 1'b0;
    item     = '0;
    exp_drop = 1'b0;
    if (m_full && srv_ready) m_full = 1'b0;
    if (acc) begin
      if (m_cnt[req_ad] < BUDGET) begin
        served = 1'b1; item.ad = req_ad; item.sub = 1'b0;
      end else if (m_cnt[3] < BUDGET) begin
        served = 1'b1; item.ad = 2'b11; item.sub = 1'b1;
      end else begin
        exp_drop = 1'b1;
      end
    end
    if (clear) begin
      for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    end
    if (served) begin
      m_cnt[item.ad] = m_cnt[item.ad] + 1;
      exp_q.push_back(item);
      m_full = 1'b1;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    model_step();
  endtask

  task automatic req(input logic [1:0] ad, input logic rdy);
    req_valid = 1'b1; req_ad = ad; srv_ready = rdy;
    cycle();
  endtask

  task automatic idle();
    req_valid = 1'b0; srv_ready = 1'b1;
    cycle();
  endtask

  task automatic clr_pulse();
    clear = 1'b1; req_valid = 1'b0; srv_ready = 1'b1;
    cycle();
    clear = 1'b0;
  endtask

  // Monitor: compares every visible output against the model once per cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      srv_t e;
      check("req_ready", int'(req_ready), int'(!m_full || srv_ready));
      check("srv_valid", int'(srv_valid), int'(exp_q.size() != 0));
      check("drop", int'(drop), int'(exp_drop));
      check("cnt_out", int'(cnt_out), m_cnt[cnt_sel]);
      if (hold) begin
        check("hold_valid", int'(srv_valid), 1);
        check("hold_ad", int'(srv_ad), int'(held.ad));
        check("hold_sub", int'(srv_sub), int'(held.sub));
      end
      hold = srv_valid && !srv_ready;
      held = {srv_ad, srv_sub};
      if (srv_valid && srv_ready) begin
        if (exp_q.size() == 0) begin
          check("srv_unexpected", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("srv_ad", int'(srv_ad), int'(e.ad));
          check("srv_sub", int'(srv_sub), int'(e.sub));
        end
      end
    end
  end

  initial begin
    checks = 0; errors = 0; mon_en = 1'b0; hold = 1'b0; held = '0;
    m_full = 1'b0; exp_drop = 1'b0;
    for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    rst_n = 1'b0; req_valid = 1'b0; req_ad = 2'b00; srv_ready = 1'b1;
    clear = 1'b0; cnt_sel = 2'b00;

    // Reset values
    #12;
    check("rst_srv_valid", int'(srv_valid), 0);
    check("rst_srv_ad", int'(srv_ad), 0);
    check("rst_srv_sub", int'(srv_sub), 0);
    check("rst_drop", int'(drop), 0);
    check("rst_cnt_out", int'(cnt_out), 0);
    check("rst_req_ready", int'(req_ready), 1);
    @(negedge clk);
    rst_n = 1'b1; mon_en = 1'b1;

    // Basic serve of 01, then read its counter
    cnt_sel = 2'b01;
    req(2'b01, 1'b1);
    check("basic_valid", int'(srv_valid), 1);
    check("basic_ad", int'(srv_ad), 1);
    idle();
    check("basic_cnt", int'(cnt_out), 1);

    // Substitution once 00 is spent
    clr_pulse();
    cnt_sel = 2'b00;
    for (int i = 0; i < BUDGET; i++) req(2'b00, 1'b1);
    req(2'b00, 1'b1);
    check("subst_flag", int'(srv_sub), 1);
    check("subst_ad", int'(srv_ad), 3);
    idle();
    check("subst_cnt0", int'(cnt_out), BUDGET);

    // Drop when both the requested ad and the fallback are spent
    clr_pulse();
    for (int i = 0; i < BUDGET; i++) req(2'b11, 1'b1);
    for (int i = 0; i < BUDGET; i++) req(2'b10, 1'b1);
    req(2'b10, 1'b1);
    check("drop_pulse", int'(drop), 1);
    idle();
    check("drop_one_cycle", int'(drop), 0);
    cnt_sel = 2'b10;
    idle();

    // Backpressure, then reload with no bubble
    clr_pulse();
    req(2'b01, 1'b1);
    for (int i = 0; i < 5; i++) begin
      req(2'b10, 1'b0);
      check("bp_ready", int'(req_ready), 0);
    end
    req(2'b10, 1'b1);
    check("reload_ad", int'(srv_ad), 2);
    check("reload_valid", int'(srv_valid), 1);
    idle();

    // Clear in the same cycle as an accepted request
    clr_pulse();
    cnt_sel = 2'b01;
    for (int i = 0; i < 3; i++) req(2'b01, 1'b1);
    clear = 1'b1;
    req(2'b01, 1'b1);
    clear = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cnt_sel = 2'(i);
      idle();
    end

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      req_valid = ($urandom_range(3) != 0);
      req_ad    = 2'($urandom_range(3));
      srv_ready = ($urandom_range(2) != 0);
      clear     = ($urandom_range(49) == 0);
      cnt_sel   = 2'($urandom_range(3));
      cycle();
    end
    clear = 1'b0;

    // Asynchronous reset while FULL with cnt0 = 5
    clr_pulse();
    cnt_sel = 2'b00;
    for (int i = 0; i < 5; i++) req(2'b00, 1'b1);
    req_valid = 1'b0; srv_ready = 1'b0;
    @(negedge clk);
    #2;
    check("pre_rst_valid", int'(srv_valid), 1);
    check("pre_rst_cnt0", int'(cnt_out), 5);
    mon_en = 1'b0;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", int'(srv_valid), 0);
    check("async_rst_cnt0", int'(cnt_out), 0);
    exp_q.delete();
    m_full = 1'b0; exp_drop = 1'b0; hold = 1'b0;
    for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    @(negedge clk);
    rst_n = 1'b1; mon_en = 1'b1;
    req(2'b00, 1'b1);
    idle();
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
